rails_feeder: RTL and testbench

RAILS_FEEDER -- requirements
Module: rails_feeder

---
 rtl/rails_feeder.sv | 212 +++++++++++++++++++++
 tb/tb_rails_feeder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rails_feeder.sv
// Double-banked case feeder: buffers host (d1,d2) pairs into two ten-entry banks and
// replays each closed case to a rail checker, tallying checker verdicts.
module rails_feeder #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_d1,
    input  logic [3:0] in_d2,
    input  logic       in_last,
    output logic [3:0] num_out,
    output logic       start,
    output logic [3:0] d1_out,
    output logic [3:0] d2_out,
    output logic       dvalid,
    input  logic       chk_valid,
    input  logic       chk_r1,
    input  logic       chk_r2,
    output logic [7:0] case_cnt,
    output logic [7:0] pass_cnt,
    output logic       timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t        state_r;
    logic [3:0]    d1_mem_r [0:1][0:9];
    logic [3:0]    d2_mem_r [0:1][0:9];
    logic [3:0]    len_r    [0:1];
    logic [1:0]    full_r;
    logic          wr_bank_r;
    logic          rd_bank_r;
    logic [3:0]    wr_idx_r;
    logic [3:0]    rd_idx_r;
    logic [CW-1:0] wait_cnt_r;

    logic          start_r;
    logic [3:0]    num_out_r;
    logic          dvalid_r;
    logic [3:0]    d1_out_r;
    logic [3:0]    d2_out_r;
    logic [7:0]    case_cnt_r;
    logic [7:0]    pass_cnt_r;
    logic          timeout_err_r;

    logic          accept_s;
    logic          close_s;
    logic          release_s;
    logic          pass_s;
    logic          timeout_hit_s;
    logic          last_beat_s;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Handshake and release decode from current registered state
    always_comb begin
        accept_s      = in_valid & ~full_r[wr_bank_r];
        close_s       = accept_s & (in_last | (wr_idx_r == 4'd9));
        timeout_hit_s = (state_r == WAIT) & ~chk_valid & (wait_cnt_r == WAIT_LAST);
        release_s     = (state_r == WAIT) & (chk_valid | (wait_cnt_r == WAIT_LAST));
        pass_s        = (state_r == WAIT) & chk_valid & chk_r1 & chk_r2;
        last_beat_s   = (rd_idx_r == (len_r[rd_bank_r] - 4'd1));
    end

    // Write side: store accepted pairs, close a case on in_last or the tenth pair
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_r <= 1'b0;
            wr_idx_r  <= 4'd0;
            for (int b = 0; b < 2; b++) begin
                len_r[b] <= 4'd0;
                for (int i = 0; i < 10; i++) begin
                    d1_mem_r[b][i] <= 4'd0;
                    d2_mem_r[b][i] <= 4'd0;
                end
            end
        end else if (accept_s) begin
            d1_mem_r[wr_bank_r][wr_idx_r] <= in_d1;
            d2_mem_r[wr_bank_r][wr_idx_r] <= in_d2;
            if (close_s) begin
                len_r[wr_bank_r] <= wr_idx_r + 4'd1;
                wr_idx_r         <= 4'd0;
                wr_bank_r        <= ~wr_bank_r;
            end else begin
                wr_idx_r <= wr_idx_r + 4'd1;
            end
        end else begin
            wr_idx_r <= wr_idx_r;
        end
    end

    // Bank full flags: a close and a release never target the same bank in one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            full_r <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (close_s && (wr_bank_r == 1'(b))) begin
                    full_r[b] <= 1'b1;
                end else if (release_s && (rd_bank_r == 1'(b))) begin
                    full_r[b] <= 1'b0;
                end else begin
                    full_r[b] <= full_r[b];
                end
            end
        end
    end

    // Read FSM with registered header/beat outputs and verdict counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            rd_bank_r     <= 1'b0;
            rd_idx_r      <= 4'd0;
            wait_cnt_r    <= '0;
            start_r       <= 1'b0;
            num_out_r     <= 4'd0;
            dvalid_r      <= 1'b0;
            d1_out_r      <= 4'd0;
            d2_out_r      <= 4'd0;
            case_cnt_r    <= 8'd0;
            pass_cnt_r    <= 8'd0;
            timeout_err_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (full_r[rd_bank_r]) begin
                        state_r   <= HDR;
                        start_r   <= 1'b1;
                        num_out_r <= len_r[rd_bank_r];
                        rd_idx_r  <= 4'd0;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                HDR: begin
                    state_r   <= SEND;
                    start_r   <= 1'b0;
                    num_out_r <= 4'd0;
                    rd_idx_r  <= 4'd0;
                    dvalid_r  <= 1'b1;
                    d1_out_r  <= d1_mem_r[rd_bank_r][0];
                    d2_out_r  <= d2_mem_r[rd_bank_r][0];
                end
                SEND: begin
                    if (last_beat_s) begin
                        state_r    <= WAIT;
                        dvalid_r   <= 1'b0;
                        d1_out_r   <= 4'd0;
                        d2_out_r   <= 4'd0;
                        wait_cnt_r <= '0;
                    end else begin
                        rd_idx_r <= rd_idx_r + 4'd1;
                        d1_out_r <= d1_mem_r[rd_bank_r][rd_idx_r + 4'd1];
                        d2_out_r <= d2_mem_r[rd_bank_r][rd_idx_r + 4'd1];
                    end
                end
                WAIT: begin
                    if (release_s) begin
                        state_r    <= IDLE;
                        wait_cnt_r <= '0;
                        rd_bank_r  <= ~rd_bank_r;
                        case_cnt_r <= sat_inc(case_cnt_r);
                        if (pass_s) begin
                            pass_cnt_r <= sat_inc(pass_cnt_r);
                        end else begin
                            pass_cnt_r <= pass_cnt_r;
                        end
                        if (timeout_hit_s) begin
                            timeout_err_r <= 1'b1;
                        end else begin
                            timeout_err_r <= timeout_err_r;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    start_r   <= 1'b0;
                    num_out_r <= 4'd0;
                    dvalid_r  <= 1'b0;
                    d1_out_r  <= 4'd0;
                    d2_out_r  <= 4'd0;
                end
            endcase
        end
    end

    assign in_ready    = ~full_r[wr_bank_r];
    assign start       = start_r;
    assign num_out     = num_out_r;
    assign dvalid      = dvalid_r;
    assign d1_out      = d1_out_r;
    assign d2_out      = d2_out_r;
    assign case_cnt    = case_cnt_r;
    assign pass_cnt    = pass_cnt_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_rails_feeder.sv
// Directed bench for rails_feeder: vector tables for case contents plus hand-timed
// sequences for latency, back-pressure, forced close, timeout, reset and saturation.
module tb_rails_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_d1;
    logic [3:0] in_d2;
    logic       in_last;
    logic [3:0] num_out;
    logic       start;
    logic [3:0] d1_out;
    logic [3:0] d2_out;
    logic       dvalid;
    logic       chk_valid;
    logic       chk_r1;
    logic       chk_r2;
    logic [7:0] case_cnt;
    logic [7:0] pass_cnt;
    logic       timeout_err;

    rails_feeder #(.TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_d1(in_d1), .in_d2(in_d2), .in_last(in_last), .num_out(num_out),
        .start(start), .d1_out(d1_out), .d2_out(d2_out), .dvalid(dvalid),
        .chk_valid(chk_valid), .chk_r1(chk_r1), .chk_r2(chk_r2),
        .case_cnt(case_cnt), .pass_cnt(pass_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d1;
        logic [3:0] d2;
        logic       last;
        logic [3:0] e1;
        logic [3:0] e2;
    } vec_t;

    int         tests = 0;
    int         failed = 0;
    int         viol = 0;
    bit         mon_en = 1'b0;
    logic [3:0] hdr_q[$];
    logic [7:0] beat_q[$];
    vec_t       v1[3];
    vec_t       v3[12];

    // Record headers and beats; count nonzero payload while its strobe is low
    always @(negedge clk) begin
        if (mon_en) begin
            if (start) hdr_q.push_back(num_out);
            if (dvalid) beat_q.push_back({d1_out, d2_out});
            if (!start && num_out != 4'd0) viol++;
            if (!dvalid && (d1_out != 4'd0 || d2_out != 4'd0)) viol++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        tests++;
        failed++;
        $display("FAIL %s: wait bound expired, expected event never seen", name);
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_d1 = 4'd0; in_d2 = 4'd0;
        chk_valid = 1'b0; chk_r1 = 1'b0; chk_r2 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        hdr_q.delete();
        beat_q.delete();
    endtask

    task automatic send_pair(input logic [3:0] a, input logic [3:0] b, input logic l);
        int n = 0;
        in_d1 = a; in_d2 = b; in_last = l; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) bound_fail("send_ready");
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_dvalid(input string name);
        int n = 0;
        while (!dvalid && n < 50) begin
            tick();
            n++;
        end
        if (!dvalid) bound_fail(name);
    endtask

    task automatic wait_beats(input int cnt, input string name);
        int n = 0;
        while (beat_q.size() < cnt && n < 200) begin
            tick();
            n++;
        end
        if (beat_q.size() < cnt) bound_fail(name);
    endtask

    task automatic pulse_chk(input logic r1, input logic r2);
        chk_valid = 1'b1; chk_r1 = r1; chk_r2 = r2;
        tick();
        chk_valid = 1'b0; chk_r1 = 1'b0; chk_r2 = 1'b0;
    endtask

    initial begin
        v1[0] = '{4'd3, 4'd3, 1'b0, 4'd3, 4'd3};
        v1[1] = '{4'd2, 4'd1, 1'b0, 4'd2, 4'd1};
        v1[2] = '{4'd1, 4'd2, 1'b1, 4'd1, 4'd2};
        for (int i = 0; i < 12; i++) begin
            v3[i] = '{4'(i + 1), 4'(15 - i), (i == 11), 4'(i + 1), 4'(15 - i)};
        end

        // Reset state
        do_reset();
        mon_en = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_start", start, 0);
        check("rst_dvalid", dvalid, 0);
        check("rst_num_out", num_out, 0);
        check("rst_case_cnt", case_cnt, 0);
        check("rst_pass_cnt", pass_cnt, 0);
        check("rst_timeout", timeout_err, 0);

        // Single case with minimum latency and consecutive beats
        for (int i = 0; i < 3; i++) send_pair(v1[i].d1, v1[i].d2, v1[i].last);
        check("t1_idle_start", start, 0);
        tick();
        check("t1_hdr_start", start, 1);
        check("t1_hdr_num", num_out, 3);
        check("t1_hdr_dvalid", dvalid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t1_beat%0d_dv", i), dvalid, 1);
            check($sformatf("t1_beat%0d_d1", i), d1_out, v1[i].e1);
            check($sformatf("t1_beat%0d_d2", i), d2_out, v1[i].e2);
            check($sformatf("t1_beat%0d_start", i), start, 0);
        end
        tick();
        check("t1_post_dvalid", dvalid, 0);
        repeat (4) tick();
        pulse_chk(1'b1, 1'b1);
        check("t1_case_cnt", case_cnt, 1);
        check("t1_pass_cnt", pass_cnt, 1);
        tick();
        pulse_chk(1'b1, 1'b1);
        check("t1_stray_case", case_cnt, 1);
        check("t1_stray_pass", pass_cnt, 1);

        // Back-pressure with two full banks, release makes the bank writable next cycle
        do_reset();
        send_pair(4'd1, 4'd1, 1'b0);
        send_pair(4'd2, 4'd2, 1'b1);
        send_pair(4'd3, 4'd3, 1'b0);
        send_pair(4'd4, 4'd4, 1'b1);
        check("t2_ready_low", in_ready, 0);
        in_d1 = 4'd5; in_d2 = 4'd5; in_last = 1'b0; in_valid = 1'b1;
        repeat (6) tick();
        check("t2_still_low", in_ready, 0);
        check("t2_no_case", case_cnt, 0);
        pulse_chk(1'b1, 1'b0);
        check("t2_ready_high", in_ready, 1);
        check("t2_case_cnt", case_cnt, 1);
        check("t2_pass_cnt", pass_cnt, 0);
        tick();
        in_valid = 1'b0;
        check("t2_next_start", start, 1);
        check("t2_next_num", num_out, 2);
        tick();
        check("t2_next_d1", d1_out, 3);

        // Forced close at ten pairs; pair eleven opens the next case
        do_reset();
        for (int i = 0; i < 12; i++) send_pair(v3[i].d1, v3[i].d2, v3[i].last);
        wait_beats(10, "t3_wait_first");
        pulse_chk(1'b1, 1'b1);
        wait_beats(12, "t3_wait_second");
        check("t3_hdr_count", hdr_q.size(), 2);
        if (hdr_q.size() >= 2) begin
            check("t3_first_num", hdr_q[0], 10);
            check("t3_second_num", hdr_q[1], 2);
        end
        check("t3_beat_count", beat_q.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < beat_q.size()) check($sformatf("t3_beat%0d", i), beat_q[i], {v3[i].e1, v3[i].e2});
        end

        // Checker timeout after 64 WAIT cycles, queued case follows
        do_reset();
        send_pair(4'd7, 4'd8, 1'b1);
        send_pair(4'd9, 4'd10, 1'b1);
        wait_dvalid("t4_wait_beat");
        check("t4_beat_d1", d1_out, 7);
        tick();
        repeat (63) tick();
        check("t4_timeout_pre", timeout_err, 0);
        check("t4_case_pre", case_cnt, 0);
        tick();
        check("t4_timeout", timeout_err, 1);
        check("t4_case_cnt", case_cnt, 1);
        check("t4_pass_cnt", pass_cnt, 0);
        tick();
        check("t4_next_start", start, 1);
        check("t4_next_num", num_out, 1);
        tick();
        check("t4_next_d1", d1_out, 9);
        tick();
        pulse_chk(1'b1, 1'b1);
        check("t4_y_case", case_cnt, 2);
        check("t4_y_pass", pass_cnt, 1);
        repeat (2) tick();
        pulse_chk(1'b1, 1'b1);
        check("t4_stray_case", case_cnt, 2);
        check("t4_stray_pass", pass_cnt, 1);
        check("t4_sticky", timeout_err, 1);

        // Reset during beat 2 of 5 discards both banks
        do_reset();
        for (int i = 0; i < 5; i++) send_pair(4'(i + 1), 4'(i + 6), (i == 4));
        send_pair(4'd12, 4'd13, 1'b1);
        wait_dvalid("t5_wait_beat");
        tick();
        check("t5_beat2_dv", dvalid, 1);
        check("t5_beat2_d1", d1_out, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_dvalid", dvalid, 0);
        check("t5_case_cnt", case_cnt, 0);
        check("t5_in_ready", in_ready, 1);
        hdr_q.delete();
        repeat (8) tick();
        check("t5_no_start", hdr_q.size(), 0);
        check("t5_ready_hold", in_ready, 1);

        // Saturation of both counters
        do_reset();
        for (int i = 0; i < 260; i++) begin
            send_pair(4'(i), 4'(i + 3), 1'b1);
            wait_dvalid("t6_wait_beat");
            tick();
            pulse_chk(1'b1, 1'b1);
        end
        check("t6_case_sat", case_cnt, 255);
        check("t6_pass_sat", pass_cnt, 255);

        check("strobe_zero", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
